debounce_sync: RTL

- Conditions a raw, asynchronous, bouncing input (push-button or slide switch) into a clean, glitch-free level for the flip-flop stage directly downstream.
- Processing chain:
  - Two-flop synchronizer on the raw input.
  - Stability counter that accepts a new level only after it has held for a programmable number of consecutive cycles.
- Outputs: the debounced level, its complement, and optional one-cycle edge pulses.

---
 rtl/debounce_pkg.sv | 14 +
 rtl/sync2.sv | 25 ++
 rtl/debounce_sync.sv | 87 ++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the debounce_sync input conditioner.
// Holds the qualification FSM state encoding and the default stability window.
package debounce_pkg;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      PEND_HIGH   = 2'd1,
      STABLE_HIGH = 2'd2,
      PEND_LOW    = 2'd3
   } db_state_t;

   localparam int DB_STABLE_CYCLES_DEFAULT = 4;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic s1_q;
   logic s2_q;

   // NOTE: sequential state is assigned with <= so both flops sample the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= d;
         s2_q <= s1_q;
      end
   end

   assign q = s2_q;

endmodule

// File: rtl/debounce_sync.sv
// Debouncer: synchronizes din, qualifies a new level over STABLE_CYCLES samples.
// Optional registered rise/fall pulses are built when DEBOUNCE_EDGE_PULSE_EN is defined.
module debounce_sync
   import debounce_pkg::*;
#(
   parameter int STABLE_CYCLES = DB_STABLE_CYCLES_DEFAULT,
   parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic q,
   output logic q_,
   output logic rise,
   output logic fall
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   logic             din_s;
   db_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             q_lvl;

   sync2 u_sync (
      .clk (clk),
      .rst (rst),
      .d   (din),
      .q   (din_s)
   );

   assign q_lvl = (state_q == STABLE_HIGH) || (state_q == PEND_LOW);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      if (din_s == q_lvl) begin
         cnt_d   = '0;
         state_d = q_lvl ? STABLE_HIGH : STABLE_LOW;
      end else if (cnt_q == CNT_MAX) begin
         cnt_d   = '0;
         state_d = din_s ? STABLE_HIGH : STABLE_LOW;
      end else begin
         cnt_d   = cnt_q + CNT_W'(1);
         state_d = q_lvl ? PEND_LOW : PEND_HIGH;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= STABLE_LOW;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign q  = q_lvl;
   assign q_ = ~q_lvl;

`ifdef DEBOUNCE_EDGE_PULSE_EN
   logic q_next;
   logic rise_q, fall_q;

   // Pulses are registered on the same edge that moves q, so they line up with it.
   assign q_next = (state_d == STABLE_HIGH) || (state_d == PEND_LOW);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise_q <= 1'b0;
         fall_q <= 1'b0;
      end else begin
         rise_q <= ~q_lvl & q_next;
         fall_q <= q_lvl & ~q_next;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;
`else
   assign rise = 1'b0;
   assign fall = 1'b0;
`endif

endmodule
